// File: rtl/e203_exu_alu_wbck_buf.sv
// rtl/e203_exu_alu_wbck_buf.sv - registered in-order write-back buffer between ALU and commit arbiter
module e203_exu_alu_wbck_buf #(
  parameter int XLEN  = 32,
  parameter int RDW   = 5,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [XLEN-1:0]           i_wdat,
  input  logic                      i_err,
  input  logic                      i_ecall,
  input  logic                      i_ebreak,
  input  logic                      i_wfi,
  input  logic [RDW-1:0]            i_rdidx,
  input  logic                      i_rdwen,

  input  logic                      flush,

  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [XLEN-1:0]           o_wdat,
  output logic                      o_err,
  output logic                      o_ecall,
  output logic                      o_ebreak,
  output logic                      o_wfi,
  output logic [RDW-1:0]            o_rdidx,
  output logic                      o_rdwen,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XLEN + RDW + 5;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready is derived from registered occupancy only, so commit-side o_ready
  // never reaches back into the ALU; nothing is accepted while in reset.
  assign i_ready = rst_n & ~full & ~flush;
  assign push    = i_valid & i_ready;

  assign o_valid = ~empty;
  assign pop     = o_valid & o_ready & ~flush;

  // Exceptions never write the register file, so rdwen is masked on entry.
  assign wr_entry = {i_wdat, i_err, i_ecall, i_ebreak, i_wfi, i_rdidx, i_rdwen & ~i_err};

  // Outputs are forced to zero when the buffer is empty.
  assign head = o_valid ? mem_q[rptr_q] : '0;
  assign {o_wdat, o_err, o_ecall, o_ebreak, o_wfi, o_rdidx, o_rdwen} = head;
  assign o_count = count_q;

  // Next-state for pointers and occupancy; flush empties by snapping rptr to wptr.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observable through head, which is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_e203_exu_alu_wbck_buf.sv
// tb/tb_e203_exu_alu_wbck_buf.sv - self-checking bench for the ALU write-back buffer
module tb_e203_exu_alu_wbck_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_wdat;
  logic        i_err, i_ecall, i_ebreak, i_wfi;
  logic [4:0]  i_rdidx;
  logic        i_rdwen;
  logic        flush;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_wdat;
  logic        o_err, o_ecall, o_ebreak, o_wfi;
  logic [4:0]  o_rdidx;
  logic        o_rdwen;
  logic [1:0]  o_count;

  logic [41:0] dut_bundle;
  assign dut_bundle = {o_wdat, o_err, o_ecall, o_ebreak, o_wfi, o_rdidx, o_rdwen};

  always #5 clk = ~clk;

  e203_exu_alu_wbck_buf #(.XLEN(32), .RDW(5), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_wdat   (i_wdat),
    .i_err    (i_err),
    .i_ecall  (i_ecall),
    .i_ebreak (i_ebreak),
    .i_wfi    (i_wfi),
    .i_rdidx  (i_rdidx),
    .i_rdwen  (i_rdwen),
    .flush    (flush),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_wdat   (o_wdat),
    .o_err    (o_err),
    .o_ecall  (o_ecall),
    .o_ebreak (o_ebreak),
    .o_wfi    (o_wfi),
    .o_rdidx  (o_rdidx),
    .o_rdwen  (o_rdwen),
    .o_count  (o_count)
  );

  typedef struct {
    logic        r, iv, fl, ordy;
    logic [31:0] wdat;
    logic [3:0]  f4;
    logic [4:0]  rdidx;
    logic        rdwen;
    logic        e_irdy, e_ov;
    logic [1:0]  e_cnt;
    logic [31:0] e_wdat;
    logic [3:0]  e_f4;
    logic [4:0]  e_rdidx;
    logic        e_rdwen;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  vec_t        tbl[$];
  logic [41:0] model_q[$];

  function automatic vec_t mk(
    input logic r, input logic iv, input logic fl, input logic ordy,
    input logic [31:0] wdat, input logic [3:0] f4, input logic [4:0] rdidx, input logic rdwen,
    input logic eirdy, input logic eov, input logic [1:0] ecnt,
    input logic [31:0] ewdat, input logic [3:0] ef4, input logic [4:0] erdidx, input logic erdwen);
    vec_t v;
    v.r = r; v.iv = iv; v.fl = fl; v.ordy = ordy;
    v.wdat = wdat; v.f4 = f4; v.rdidx = rdidx; v.rdwen = rdwen;
    v.e_irdy = eirdy; v.e_ov = eov; v.e_cnt = ecnt;
    v.e_wdat = ewdat; v.e_f4 = ef4; v.e_rdidx = erdidx; v.e_rdwen = erdwen;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic iv, input logic fl, input logic ordy,
                       input logic [31:0] wdat, input logic [3:0] f4,
                       input logic [4:0] rdidx, input logic rdwen);
    rst_n    = r;
    i_valid  = iv;
    flush    = fl;
    o_ready  = ordy;
    i_wdat   = wdat;
    {i_err, i_ecall, i_ebreak, i_wfi} = f4;
    i_rdidx  = rdidx;
    i_rdwen  = rdwen;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // f4 ordering throughout: {err, ecall, ebreak, wfi}
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0, 32'hdead_beef,4'b0000,5'd3,1'b1, 1'b0,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h1234_5678,4'b0000,5'd5,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b1,2'd1, 32'h1234_5678,4'b0000,5'd5,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'h1,4'b0000,5'd1,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'h2,4'b0000,5'd2,1'b1, 1'b1,1'b1,2'd1, 32'h1,4'b0000,5'd1,1'b1));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'h3,4'b0000,5'd3,1'b1, 1'b0,1'b1,2'd2, 32'h1,4'b0000,5'd1,1'b1));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h3,4'b0000,5'd3,1'b1, 1'b0,1'b1,2'd2, 32'h1,4'b0000,5'd1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b1,2'd1, 32'h2,4'b0000,5'd2,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b1,2'd1, 32'h2,4'b0000,5'd2,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'habc,4'b1100,5'd7,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b1,2'd1, 32'habc,4'b1100,5'd7,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h55,4'b1010,5'd3,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h66,4'b0000,5'd4,1'b1, 1'b1,1'b1,2'd1, 32'h55,4'b1010,5'd3,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h77,4'b1001,5'd9,1'b1, 1'b1,1'b1,2'd1, 32'h66,4'b0000,5'd4,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b1,2'd1, 32'h77,4'b1001,5'd9,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'ha1,4'b0000,5'd1,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'ha2,4'b0000,5'd2,1'b1, 1'b1,1'b1,2'd1, 32'ha1,4'b0000,5'd1,1'b1));
    tbl.push_back(mk(1'b1,1'b1,1'b1,1'b1, 32'ha3,4'b0000,5'd3,1'b1, 1'b0,1'b1,2'd2, 32'ha1,4'b0000,5'd1,1'b1));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'hb1,4'b0000,5'd6,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b1,2'd1, 32'hb1,4'b0000,5'd6,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0, 32'hc1,4'b0000,5'd1,1'b1, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));
    tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0, 32'hc2,4'b0000,5'd2,1'b1, 1'b0,1'b1,2'd1, 32'hc1,4'b0000,5'd1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0, 32'h0,4'b0000,5'd0,1'b0, 1'b1,1'b0,2'd0, 32'h0,4'b0000,5'd0,1'b0));

    // Initial reset edge with a valid input present.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hdead_beef, 4'b0000, 5'd3, 1'b1);
    next_cycle();

    // Directed table: inputs applied, current-cycle outputs checked before the edge.
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].wdat, tbl[i].f4, tbl[i].rdidx, tbl[i].rdwen);
      #4;
      chk($sformatf("row%0d_i_ready", i), 64'(i_ready), 64'(tbl[i].e_irdy));
      chk($sformatf("row%0d_o_valid", i), 64'(o_valid), 64'(tbl[i].e_ov));
      chk($sformatf("row%0d_o_count", i), 64'(o_count), 64'(tbl[i].e_cnt));
      chk($sformatf("row%0d_o_data", i), 64'(dut_bundle),
          64'({tbl[i].e_wdat, tbl[i].e_f4, tbl[i].e_rdidx, tbl[i].e_rdwen}));
      next_cycle();
    end

    // Streaming: 16 back-to-back pushes with o_ready held high.
    for (int c = 0; c < 18; c++) begin
      logic [4:0] ri;
      ri = 5'(c);
      drive(1'b1, (c < 16), 1'b0, 1'b1, 32'h100 + 32'(c), 4'b0000, ri, 1'b1);
      #4;
      chk($sformatf("stream%0d_i_ready", c), 64'(i_ready), 64'(1));
      chk($sformatf("stream%0d_o_valid", c), 64'(o_valid), 64'((c >= 1) && (c <= 16)));
      chk($sformatf("stream%0d_o_count", c), 64'(o_count), 64'((c >= 1) && (c <= 16)));
      if (c >= 1 && c <= 16) begin
        chk($sformatf("stream%0d_o_wdat", c), 64'(o_wdat), 64'(32'h100 + 32'(c - 1)));
      end
      next_cycle();
    end

    // Randomized traffic against a queue reference; buffer is empty here.
    model_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic        r, iv, fl, ordy, rdwen, e_irdy, e_ov, do_pop, do_push;
      logic [31:0] wdat;
      logic [3:0]  f4;
      logic [4:0]  rdidx;
      logic [41:0] e_data;
      r     = ($urandom_range(0, 99) != 0);
      iv    = ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 15) == 0);
      ordy  = 1'($urandom_range(0, 1));
      wdat  = $urandom;
      f4    = 4'($urandom_range(0, 15));
      rdidx = 5'($urandom_range(0, 31));
      rdwen = 1'($urandom_range(0, 1));
      drive(r, iv, fl, ordy, wdat, f4, rdidx, rdwen);

      e_irdy = r && (model_q.size() < DEPTH) && !fl;
      e_ov   = (model_q.size() != 0);
      e_data = e_ov ? model_q[0] : 42'h0;
      #4;
      chk($sformatf("rand%0d_i_ready", n), 64'(i_ready), 64'(e_irdy));
      chk($sformatf("rand%0d_o_valid", n), 64'(o_valid), 64'(e_ov));
      chk($sformatf("rand%0d_o_count", n), 64'(o_count), 64'(model_q.size()));
      chk($sformatf("rand%0d_o_data", n), 64'(dut_bundle), 64'(e_data));

      if (!r || fl) begin
        model_q.delete();
      end else begin
        do_pop  = e_ov && ordy;
        do_push = iv && e_irdy;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back({wdat, f4, rdidx, rdwen & ~f4[3]});
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
